wb_sram_ctrl: RTL and testbench
===============================

// Module: wb_sram_ctrl
// PURPOSE
//  Wishbone slave that sits downstream of the CPU data bus (dbus) and services
//  its requests against an external 32-bit asynchronous SRAM.
//  - Latches one classic-cycle request and drives SRAM CE/OE/WE/BE for a
//    programmable number of cycles.
//  - Returns a single-cycle ACK, with read data on reads.
//  - Registers every SRAM control output, so the pins are glitch-free.
// PARAMETERS
//  ADDR_WIDTH   20  SRAM word-address width; uses wb_adr_i[ADDR_WIDTH+1:2]
//  WAIT_CYCLES  2   cycles the SRAM strobe is held per access (legal range 1..15)
// PORTS
//  clk          in   1           system clock; all logic on posedge
//  rst_n        in   1           asynchronous reset, active-low
//  wb_cyc_i     in   1           Wishbone cycle valid
//  wb_stb_i     in   1           Wishbone strobe
//  wb_we_i      in   1           1 = write, 0 = read
//  wb_adr_i     in   32          byte address; bits [1:0] ignored
//  wb_sel_i     in   4           byte lane selects; bit i selects dat[8i+7:8i]
//  wb_dat_i     in   32          write data
//  wb_dat_o     out  32          read data; valid while wb_ack_o=1 on a read
//  wb_ack_o     out  1           one-cycle transfer acknowledge
//  sram_addr_o  out  ADDR_WIDTH  SRAM word address
//  sram_dq_o    out  32          SRAM write data
//  sram_dq_oe_o out  1           1 = drive the DQ bus (top level owns the tristate)
//  sram_dq_i    in   32          SRAM read data
//  sram_ce_n_o  out  1           chip enable, active-low
//  sram_oe_n_o  out  1           output enable, active-low
//  sram_we_n_o  out  1           write enable, active-low
//  sram_be_n_o  out  4           byte enables, active-low (= ~sel)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state = IDLE.
//   - ce_n, oe_n, we_n = 1; be_n = 4'hF.
//   - dq_oe = 0; addr, dq_o, dat_o = 0; ack = 0.
//   - Takes effect immediately, even mid-access; no ACK is ever issued for an
//     access interrupted by reset.
//  FSM: IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE:
//   - If cyc&stb, latch adr, sel, we, dat_i and load the counter with
//     WAIT_CYCLES; go to ACCESS.
//   - The SRAM control outputs take their new values on the same clock edge.
//  ACCESS:
//   - ce_n = 0, be_n = ~sel.
//   - Read: oe_n = 0, we_n = 1, dq_oe = 0.
//   - Write: oe_n = 1, we_n = 0, dq_oe = 1, dq_o = latched data.
//   - The counter decrements each cycle. On the cycle it equals 1, a read
//     samples sram_dq_i into wb_dat_o; then go to DONE.
//  DONE:
//   - ce_n, oe_n, we_n = 1.
//   - Write: dq_oe stays 1 for this cycle (data hold after WE rise), then 0.
//   - wb_ack_o = 1 for exactly this cycle, and only if wb_cyc_i=1.
//   - Go to IDLE unconditionally.
//  Timing:
//   - Latency: request seen at edge T -> ack high in cycle T+WAIT_CYCLES+1.
//   - Back-to-back requests: one per WAIT_CYCLES+2 cycles.
//   - A request held high after its ACK is treated as a new request in IDLE.
//  Boundary conditions:
//   - Master drops cyc mid-access: the SRAM access still completes (writes are
//     never torn) and the ACK is suppressed.
//   - Request inputs are ignored outside IDLE; the latched values are used.
//   - sel = 4'h0: full timing runs with be_n = 4'hF, and ACK is still given.
//   - wb_dat_o holds its value until the next read completes.
//   - Address bits above ADDR_WIDTH+1 are discarded, so the address wraps.
// TESTING
//  1. Reset: hold rst_n=0 mid-write -> ce_n/we_n = 1 and dq_oe = 0 immediately;
//     no ack after release.
//  2. Write then read: write adr=0x0000_0010, dat=0xDEADBEEF, sel=F ->
//     sram_addr=0x4, we_n low 2 cycles, ack at T+3.
//     Then read the same address -> dat_o=0xDEADBEEF.
//  3. Byte write: sel=4'b0010, dat=0x0000_AB00 at an address holding
//     0x11223344 -> be_n=4'b1101, readback 0x1122AB44.
//  4. Back-to-back: hold cyc/stb for 3 reads -> acks spaced exactly 4 cycles
//     apart (WAIT_CYCLES=2).
//  5. Abort: drop cyc one cycle into a write -> we_n pulse is still full length,
//     ack stays 0, FSM returns to IDLE.
//  6. WAIT_CYCLES=1 build: read -> oe_n low 1 cycle, ack at T+2; sel=0 read
//     still acks with be_n=F.

Source files
------------

// File: rtl/wb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// wb_sram_ctrl
//
// Wishbone classic-cycle slave that performs one access at a time against an
// external 32-bit asynchronous SRAM. A request is latched in IDLE. The SRAM
// strobes are then held for WAIT_CYCLES cycles, followed by one DONE cycle
// that carries the single-cycle acknowledge. Every SRAM pin and every
// Wishbone output comes straight from a flop, so the pins are glitch-free.
//
// Parameters
//   ADDR_WIDTH   SRAM word-address width (uses wb_adr_i[ADDR_WIDTH+1:2])
//   WAIT_CYCLES  strobe length per access, 1..15
//
// Ports
//   clk, rst_n            clock (posedge) / asynchronous active-low reset
//   wb_cyc_i, wb_stb_i    Wishbone cycle / strobe
//   wb_we_i               1 = write, 0 = read
//   wb_adr_i              byte address; [1:0] and bits above ADDR_WIDTH+1
//                         are ignored
//   wb_sel_i              byte lane selects
//   wb_dat_i / wb_dat_o   write data / read data (held until the next read)
//   wb_ack_o              one-cycle acknowledge
//   sram_addr_o           SRAM word address
//   sram_dq_o/_oe_o/_i    SRAM data out / drive enable / data in
//   sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
//                         active-low SRAM controls
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module wb_sram_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 20,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]           sram_dq_o,
    output logic                  sram_dq_oe_o,
    input  logic [31:0]           sram_dq_i,
    output logic                  sram_ce_n_o,
    output logic                  sram_oe_n_o,
    output logic                  sram_we_n_o,
    output logic [3:0]            sram_be_n_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             dq_q, dq_d;
    logic                    dq_oe_q, dq_oe_d;
    logic                    ce_n_q, ce_n_d;
    logic                    oe_n_q, oe_n_d;
    logic                    we_n_q, we_n_d;
    logic [3:0]              be_n_q, be_n_d;
    logic [31:0]             dat_q, dat_d;
    logic                    ack_q, ack_d;

    // Address bits outside the word-address window are deliberately dropped.
    logic unused_s;
    assign unused_s = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};

    // Next-state and next-output logic; all pins are computed one cycle ahead.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        dq_d    = dq_q;
        dq_oe_d = dq_oe_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        be_n_d  = be_n_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    state_d = ST_ACCESS;
                    cnt_d   = WAIT_LOAD;
                    we_d    = wb_we_i;
                    addr_d  = wb_adr_i[ADDR_WIDTH+1:2];
                    dq_d    = wb_dat_i;
                    ce_n_d  = 1'b0;
                    be_n_d  = ~wb_sel_i;
                    if (wb_we_i) begin
                        oe_n_d  = 1'b1;
                        we_n_d  = 1'b0;
                        dq_oe_d = 1'b1;
                    end else begin
                        oe_n_d  = 1'b0;
                        we_n_d  = 1'b1;
                        dq_oe_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    // Last strobe cycle: release the strobes, but keep dq_oe
                    // for one more cycle so write data is held past WE rise.
                    state_d = ST_DONE;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    be_n_d  = 4'hF;
                    // An aborted cycle still completes, silently.
                    ack_d   = wb_cyc_i;
                    if (!we_q) begin
                        dat_d = sram_dq_i;
                    end else begin
                        dat_d = dat_q;
                    end
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                dq_oe_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                be_n_d  = 4'hF;
                dq_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset parks the SRAM deselected at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dq_q    <= 32'h0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            be_n_q  <= 4'hF;
            dat_q   <= 32'h0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            dq_oe_q <= dq_oe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            be_n_q  <= be_n_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
        end
    end

    assign wb_dat_o     = dat_q;
    assign wb_ack_o     = ack_q;
    assign sram_addr_o  = addr_q;
    assign sram_dq_o    = dq_q;
    assign sram_dq_oe_o = dq_oe_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_be_n_o  = be_n_q;

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_sram_ctrl
//
// Two controller instances: dut_a (WAIT_CYCLES=2) and dut_b (WAIT_CYCLES=1),
// each with its own pin-level SRAM model. A Wishbone master task drives one
// instance at a time (selected by dsel) and checks pin timing, latency,
// acknowledge and read data. Expected read data comes from the vector table
// or from a word-addressed reference memory updated with byte-lane merges.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_sram_ctrl;

    logic        clk, rst_n, mem_clr, dsel;
    logic        cyc, stb, we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;

    logic        ack_a, dqoe_a, ce_a, oe_a, we_a;
    logic [31:0] dat_a, dq_a, dqi_a;
    logic [19:0] addr_a;
    logic [3:0]  be_a;
    logic        ack_b, dqoe_b, ce_b, oe_b, we_b;
    logic [31:0] dat_b, dq_b, dqi_b;
    logic [19:0] addr_b;
    logic [3:0]  be_b;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] ref_mem [int];

    int total  = 0;
    int passed = 0;

    wb_sram_ctrl #(.ADDR_WIDTH(20), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(cyc & ~dsel), .wb_stb_i(stb & ~dsel), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat),
        .wb_dat_o(dat_a), .wb_ack_o(ack_a),
        .sram_addr_o(addr_a), .sram_dq_o(dq_a), .sram_dq_oe_o(dqoe_a),
        .sram_dq_i(dqi_a), .sram_ce_n_o(ce_a), .sram_oe_n_o(oe_a),
        .sram_we_n_o(we_a), .sram_be_n_o(be_a)
    );

    wb_sram_ctrl #(.ADDR_WIDTH(20), .WAIT_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(cyc & dsel), .wb_stb_i(stb & dsel), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat),
        .wb_dat_o(dat_b), .wb_ack_o(ack_b),
        .sram_addr_o(addr_b), .sram_dq_o(dq_b), .sram_dq_oe_o(dqoe_b),
        .sram_dq_i(dqi_b), .sram_ce_n_o(ce_b), .sram_oe_n_o(oe_b),
        .sram_we_n_o(we_b), .sram_be_n_o(be_b)
    );

    // Observation of whichever instance is currently selected.
    logic        ack_m, dqoe_m, ce_m, oe_m, we_m;
    logic [31:0] dat_m, dq_m;
    logic [19:0] addr_m;
    logic [3:0]  be_m;
    assign ack_m  = dsel ? ack_b  : ack_a;
    assign dqoe_m = dsel ? dqoe_b : dqoe_a;
    assign ce_m   = dsel ? ce_b   : ce_a;
    assign oe_m   = dsel ? oe_b   : oe_a;
    assign we_m   = dsel ? we_b   : we_a;
    assign dat_m  = dsel ? dat_b  : dat_a;
    assign dq_m   = dsel ? dq_b   : dq_a;
    assign addr_m = dsel ? addr_b : addr_a;
    assign be_m   = dsel ? be_b   : be_a;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    // SRAM pin models: byte-masked write on every clock while WE is low.
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] ben);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (!ben[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= 32'h0;
        end else if (!ce_a && !we_a) begin
            mem_a[addr_a[7:0]] <= merge(mem_a[addr_a[7:0]], dq_a, be_a);
        end
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= 32'h0;
        end else if (!ce_b && !we_b) begin
            mem_b[addr_b[7:0]] <= merge(mem_b[addr_b[7:0]], dq_b, be_b);
        end
    end

    assign dqi_a = (!ce_a && !oe_a) ? mem_a[addr_a[7:0]] : 32'h5A5A_5A5A;
    assign dqi_b = (!ce_b && !oe_b) ? mem_b[addr_b[7:0]] : 32'h5A5A_5A5A;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] ref_rd(input int wi);
        return ref_mem.exists(wi) ? ref_mem[wi] : 32'h0;
    endfunction

    // Reference write: bytes whose select is set take the new data.
    task automatic ref_wr(input int wi, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] w;
        w = ref_rd(wi);
        for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        ref_mem[wi] = w;
    endtask

    // One complete classic cycle on the selected instance.
    task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] exp_rd);
        int   wc;
        int   strobes;
        int   lat;
        logic got;
        logic [19:0] ea;
        wc = dsel ? 1 : 2;
        strobes = 0;
        lat = 0;
        got = 1'b0;
        ea = a[21:2];
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
        @(posedge clk); #1;
        chk("start_ctl", {ce_m, oe_m, we_m, be_m, dqoe_m}, {1'b0, w, ~w, ~s, w});
        chk("start_addr", addr_m, ea);
        if (w) chk("start_wdata", dq_m, d);
        strobes = w ? int'(!we_m) : int'(!oe_m);
        // Scramble the request while the access runs; latched values rule.
        we = ~w; adr = ~a; sel = ~s; dat = ~d;
        for (int k = 1; k <= 20; k++) begin
            if (!got) begin
                @(posedge clk); #1;
                if (ack_m) begin
                    got = 1'b1;
                    lat = k;
                end else begin
                    strobes += w ? int'(!we_m) : int'(!oe_m);
                end
            end
        end
        chk("ack_seen", got, 1'b1);
        chk("latency", lat, wc);
        chk("strobe_len", strobes, wc);
        cyc = 1'b0; stb = 1'b0;
        chk("done_ctl", {ce_m, oe_m, we_m, dqoe_m}, {3'b111, w});
        if (!w) chk("rd_data", dat_m, exp_rd);
        @(posedge clk); #1;
        chk("post_ctl", {ack_m, dqoe_m, ce_m}, 3'b001);
        if (!w) chk("rd_hold", dat_m, exp_rd);
        if (w && !dsel) ref_wr(int'(ea), s, d);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int   acks;
        int   t [3];
        int   lows;
        logic saw;
        logic rw;
        int   word;

        tbl[0] = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0};
        tbl[1] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF};
        tbl[2] = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'h0};
        tbl[3] = '{1'b1, 32'h0000_0020, 4'h2, 32'h0000_AB00, 32'h0};
        tbl[4] = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         32'h1122_AB44};
        tbl[5] = '{1'b0, 32'hFFC0_0013, 4'hF, 32'h0,         32'hDEAD_BEEF};
        tbl[6] = '{1'b1, 32'h0000_0024, 4'h0, 32'hCAFE_F00D, 32'h0};
        tbl[7] = '{1'b0, 32'h0000_0024, 4'hF, 32'h0,         32'h0000_0000};
        tbl[8] = '{1'b1, 32'h0000_03FC, 4'h9, 32'hA1B2_C3D4, 32'h0};
        tbl[9] = '{1'b0, 32'h0000_03FC, 4'h6, 32'h0,         32'hA100_00D4};

        rst_n = 1'b0; mem_clr = 1'b1; dsel = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0; sel = 4'h0; dat = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {ce_a, oe_a, we_a, be_a, dqoe_a, ack_a}, 9'b1_1_1_1111_0_0);
        chk("rst_addr", addr_a, 20'h0);
        chk("rst_dq", dq_a, 32'h0);
        chk("rst_dat", dat_a, 32'h0);
        mem_clr = 1'b0; rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 10; i++) txn(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d, tbl[i].exp);

        // Randomized accesses against the reference memory.
        for (int i = 0; i < 40; i++) begin
            rw   = 1'($urandom_range(0, 1));
            word = int'($urandom_range(0, 255));
            txn(rw, {10'($urandom), 12'h0, 8'(word), 2'($urandom)}, 4'($urandom),
                $urandom, ref_rd(word));
        end

        // Back-to-back: request held for three reads.
        acks = 0;
        t[0] = 0; t[1] = 0; t[2] = 0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0010; sel = 4'hF;
        for (int k = 0; k < 40; k++) begin
            if (acks < 3) begin
                @(posedge clk); #1;
                if (ack_m) begin
                    t[acks] = k;
                    chk("b2b_data", dat_m, ref_rd(4));
                    acks++;
                    if (acks == 3) begin
                        cyc = 1'b0; stb = 1'b0;
                    end
                end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        chk("b2b_count", acks, 3);
        chk("b2b_gap1", t[1] - t[0], 4);
        chk("b2b_gap2", t[2] - t[1], 4);
        repeat (2) @(posedge clk);

        // Abort: master drops cyc one cycle into a write.
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_0030; sel = 4'hF;
        dat = 32'h1234_5678;
        @(posedge clk); #1;
        lows = int'(!we_m);
        saw = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0000_0044; sel = 4'h0; dat = 32'h0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            lows += int'(!we_m);
            saw = saw | ack_m;
        end
        chk("abort_we_len", lows, 2);
        chk("abort_no_ack", saw, 1'b0);
        chk("abort_idle", {ce_m, we_m, dqoe_m}, 3'b110);
        ref_wr(12, 4'hF, 32'h1234_5678);
        txn(1'b0, 32'h0000_0030, 4'hF, 32'h0, ref_rd(12));

        // Reset in the middle of a write.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_03F0; sel = 4'hF;
        dat = 32'h7777_7777;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_ctl", {ce_m, we_m, dqoe_m}, 3'b110);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            saw = saw | ack_m;
        end
        chk("rstmid_no_ack", saw, 1'b0);

        // Single-wait-cycle instance.
        dsel = 1'b1;
        txn(1'b1, 32'h0000_0040, 4'hF, 32'h0BAD_CAFE, 32'h0);
        txn(1'b0, 32'h0000_0040, 4'hF, 32'h0,         32'h0BAD_CAFE);
        txn(1'b0, 32'h0000_0040, 4'h0, 32'h0,         32'h0BAD_CAFE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
